// File: rtl/ps2_key_event_fifo_if.sv
// Scan-byte input and key-event output handshake between the PS/2 receiver,
// the key-event decoder/FIFO and its consumer.
interface ps2_key_event_fifo_if;
  logic [7:0]  scan_byte;
  logic        scan_valid;
  logic [15:0] ev_data;
  logic        ev_valid;
  logic        ev_ready;

  // System side: supplies scan bytes and consumes events.
  modport master (
    output scan_byte,
    output scan_valid,
    output ev_ready,
    input  ev_data,
    input  ev_valid
  );

  // Decoder/FIFO side.
  modport slave (
    input  scan_byte,
    input  scan_valid,
    input  ev_ready,
    output ev_data,
    output ev_valid
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// Set-2 scan-code decoder feeding a first-word-fall-through event FIFO.
// Each event word: {break, extended, shift_held, 5'b0, code}.
module ps2_key_event_fifo #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  ps2_key_event_fifo_if.slave   bus,
  output logic [CW-1:0]         fifo_count,
  output logic                  overflow,
  output logic                  shift_held
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state;
  logic          shift_l, shift_r;
  logic          shift_l_nxt, shift_r_nxt;
  logic          is_resp, is_e0, is_f0, emit, ev_brk, ev_ext;
  logic [15:0]   ev_word;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [15:0]   head_q, head_nxt;
  logic          valid_q;
  logic          full, pop, push, drop;

  assign bus.ev_data  = head_q;
  assign bus.ev_valid = valid_q;

  // Classify the incoming byte and form the candidate event and shift flags.
  always_comb begin
    is_resp = bus.scan_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    is_e0   = (bus.scan_byte == 8'hE0);
    is_f0   = (bus.scan_byte == 8'hF0);
    ev_brk  = (state == GOT_F0) || (state == GOT_E0F0);
    ev_ext  = (state == GOT_E0) || (state == GOT_E0F0);
    emit    = bus.scan_valid && !is_resp && !is_e0 && !is_f0;
    ev_word = {ev_brk, ev_ext, shift_held, 5'b0, bus.scan_byte};
    shift_l_nxt = shift_l;
    shift_r_nxt = shift_r;
    if (emit && !ev_ext && bus.scan_byte == 8'h12) shift_l_nxt = !ev_brk;
    if (emit && !ev_ext && bus.scan_byte == 8'h59) shift_r_nxt = !ev_brk;
  end

  // Prefix-tracking decoder state plus registered shift flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      shift_held <= 1'b0;
    end else if (bus.scan_valid) begin
      if (is_resp)    state <= IDLE;
      else if (is_e0) state <= GOT_E0;
      else if (is_f0) state <= ev_ext ? GOT_E0F0 : GOT_F0;
      else            state <= IDLE;
      shift_l    <= shift_l_nxt;
      shift_r    <= shift_r_nxt;
      shift_held <= shift_l_nxt | shift_r_nxt;
    end
  end

  // FIFO control; the head register bypasses the new word when the FIFO
  // would otherwise be empty after this cycle's pop.
  always_comb begin
    full       = (fifo_count == CW'(DEPTH));
    pop        = valid_q && bus.ev_ready;
    push       = emit && (!full || pop);
    drop       = emit && full && !pop;
    count_nxt  = fifo_count + CW'(push) - CW'(pop);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    if (count_nxt == '0)
      head_nxt = head_q;
    else if (push && (fifo_count - CW'(pop)) == '0)
      head_nxt = ev_word;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  // Storage array: no reset needed, contents are qualified by the count.
  always_ff @(posedge CLK) begin
    if (push && !reset) mem[wr_ptr] <= ev_word;
  end

  // Pointers, count, registered head/valid and sticky overflow.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      head_q     <= head_nxt;
      valid_q    <= (count_nxt != '0);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: directed vector table,
// overflow / full-FIFO sequences, then random bytes against a queue model.
module tb_ps2_key_event_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          shift_held;

  ps2_key_event_fifo_if bus ();

  ps2_key_event_fifo #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .shift_held (shift_held)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending events, prefix flags, shift flags.
  logic [15:0] m_q [$];
  logic        m_ov, m_l, m_r, m_e0, m_f0;

  function automatic void model_step(input logic r, input logic v,
                                     input logic [7:0] b, input logic rdy);
    logic        have_ev;
    logic [15:0] ev;
    have_ev = 1'b0;
    ev      = '0;
    if (r) begin
      m_q.delete();
      m_ov = 0; m_l = 0; m_r = 0; m_e0 = 0; m_f0 = 0;
      return;
    end
    if (v) begin
      if (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
          b == 8'hFE || b == 8'hFF) begin
        m_e0 = 0; m_f0 = 0;
      end else if (b == 8'hE0) begin
        m_e0 = 1; m_f0 = 0;
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else begin
        ev = {m_f0, m_e0, (m_l | m_r), 5'b0, b};
        have_ev = 1'b1;
        if (!m_e0 && b == 8'h12) m_l = !m_f0;
        if (!m_e0 && b == 8'h59) m_r = !m_f0;
        m_e0 = 0; m_f0 = 0;
      end
    end
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (have_ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ov = 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b, input logic rdy);
    @(negedge CLK);
    reset          = r;
    bus.scan_valid = v;
    bus.scan_byte  = b;
    bus.ev_ready   = rdy;
    model_step(r, v, b, rdy);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  b;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_data;
    int          e_count;
    logic        e_ov;
    logic        e_shift;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkv(input logic rst, input logic v, input logic [7:0] b,
                               input logic rdy, input logic ev, input logic [15:0] ed,
                               input int ec, input logic eo, input logic es);
    vec_t t;
    t.rst = rst; t.v = v; t.b = b; t.rdy = rdy;
    t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_ov = eo; t.e_shift = es;
    return t;
  endfunction

  logic [7:0] pool [12];

  initial begin
    bus.scan_byte  = '0;
    bus.scan_valid = 1'b0;
    bus.ev_ready   = 1'b0;
    m_ov = 0; m_l = 0; m_r = 0; m_e0 = 0; m_f0 = 0;

    //           rst v  byte   rdy valid data     cnt ov shift
    tbl.push_back(mkv(1, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h1C, 0, 1, 16'h001C, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hF0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h1C, 0, 1, 16'h801C, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hE0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h75, 0, 1, 16'h4075, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hE0, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hF0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h75, 0, 1, 16'hC075, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h12, 0, 1, 16'h0012, 1, 0, 1));
    tbl.push_back(mkv(0, 1, 8'h1C, 0, 1, 16'h0012, 2, 0, 1));
    tbl.push_back(mkv(0, 1, 8'hF0, 0, 1, 16'h0012, 2, 0, 1));
    tbl.push_back(mkv(0, 1, 8'h12, 0, 1, 16'h0012, 3, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h1C, 0, 1, 16'h0012, 4, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 1, 16'h201C, 3, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 1, 16'hA012, 2, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 1, 16'h001C, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h12, 0, 1, 16'h0012, 1, 0, 1));
    tbl.push_back(mkv(0, 1, 8'hF0, 0, 1, 16'h0012, 1, 0, 1));
    tbl.push_back(mkv(1, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h1C, 0, 1, 16'h001C, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hE0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hFA, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h75, 0, 1, 16'h0075, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h75, 1, 1, 16'h0075, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 8'hE0, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h59, 0, 1, 16'h4059, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 8'h59, 1, 1, 16'h0059, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].rdy);
      chk($sformatf("vec%0d ev_valid", i), 32'(bus.ev_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d shift_held", i), 32'(shift_held), 32'(tbl[i].e_shift));
      if (tbl[i].e_valid || tbl[i].rst)
        chk($sformatf("vec%0d ev_data", i), 32'(bus.ev_data), 32'(tbl[i].e_data));
    end

    // Overflow: nine makes into an 8-deep FIFO, the ninth is dropped.
    step(1, 0, 8'h00, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 8'(i), 0);
      chk($sformatf("fill%0d count", i), 32'(fifo_count), (i > DEPTH) ? DEPTH : i);
      chk($sformatf("fill%0d overflow", i), 32'(overflow), (i == 9) ? 1 : 0);
    end
    chk("fill head", 32'(bus.ev_data), 32'h0001);
    for (int j = 1; j <= DEPTH; j++) begin
      step(0, 0, 8'h00, 1);
      if (j < DEPTH) begin
        chk($sformatf("drain%0d data", j), 32'(bus.ev_data), 32'(j + 1));
        chk($sformatf("drain%0d count", j), 32'(fifo_count), 32'(DEPTH - j));
      end else begin
        chk("drain empty valid", 32'(bus.ev_valid), 0);
      end
    end
    chk("drain overflow sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous push and pop: no drop.
    step(1, 0, 8'h00, 0);
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'h0A, 1);
    chk("fullpp count", 32'(fifo_count), DEPTH);
    chk("fullpp overflow", 32'(overflow), 0);
    chk("fullpp head", 32'(bus.ev_data), 32'h0002);
    chk("fullpp valid", 32'(bus.ev_valid), 1);

    // Random traffic against the reference model.
    pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h1C, 8'h75, 8'hE0, 8'hF0,
             8'hFA, 8'hAA, 8'h12, 8'h59};
    step(1, 0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      logic       r, v, rdy;
      logic [7:0] b;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 7));
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step(r, v, b, rdy);
      chk("rnd ev_valid", 32'(bus.ev_valid), (m_q.size() != 0) ? 1 : 0);
      chk("rnd fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("rnd overflow", 32'(overflow), 32'(m_ov));
      chk("rnd shift_held", 32'(shift_held), 32'(m_l | m_r));
      if (m_q.size() != 0) chk("rnd ev_data", 32'(bus.ev_data), 32'(m_q[0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
